boot_sequencer: RTL and testbench

// Sits between wordReceiver and the instruction ROM write port / processor reset. After reset it

---
 rtl/boot_sequencer.sv | 147 ++++++++++++++
 tb/tb_boot_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the CPU in reset, loads a bootloader image into instruction
// memory word by word, then releases the CPU (or boots the preloaded ROM on timeout).
module boot_sequencer #(
  parameter int          ADDR_W       = 12,
  parameter logic [15:0] MAGIC        = 16'hB007,
  parameter int          BOOT_TIMEOUT = 1000000,
  parameter int          WORD_TIMEOUT = 100000,
  parameter int          RESET_HOLD   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic [ADDR_W-1:0] word_addr,
  output logic              imem_wEn,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        state_dbg
);

  // Handshake: word_valid is a one-cycle strobe with no back-pressure; every strobe is
  // consumed in the cycle it is presented, so back-to-back strobes yield back-to-back writes.

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam int BT_W = $clog2(BOOT_TIMEOUT + 1);
  localparam int WT_W = $clog2(WORD_TIMEOUT + 1);
  localparam int HT_W = $clog2(RESET_HOLD + 1);
  localparam logic [BT_W-1:0]  BOOT_LAST = BT_W'(BOOT_TIMEOUT - 1);
  localparam logic [WT_W-1:0]  WORD_LAST = WT_W'(WORD_TIMEOUT - 1);
  localparam logic [HT_W-1:0]  HOLD_LAST = HT_W'(RESET_HOLD - 1);
  localparam logic [ADDR_W:0]  MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W+1)'(1);

  state_t              state;
  logic [BT_W-1:0]     wait_timer;
  logic [WT_W-1:0]     idle_timer;
  logic [HT_W-1:0]     hold_cnt;
  logic [ADDR_W-1:0]   expected;
  logic [ADDR_W:0]     load_len;
  logic [ADDR_W:0]     hdr_len;
  logic                hdr_ok;
  logic                last_word;
  wire                 unused_ok = &{1'b0, word_data};

  assign hdr_len   = word_data[ADDR_W:0];
  assign hdr_ok    = word_valid && (word_data[31:16] == MAGIC) &&
                     (hdr_len != '0) && (hdr_len <= MAX_LEN);
  assign last_word = ({1'b0, expected} == (load_len - LEN_ONE));
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_WAIT;
      wait_timer <= '0;
      idle_timer <= '0;
      hold_cnt   <= '0;
      expected   <= '0;
      load_len   <= '0;
      imem_wEn   <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
      word_count <= '0;
    end else begin
      imem_wEn <= 1'b0;
      case (state)
        S_WAIT: begin
          wait_timer <= wait_timer + BT_W'(1);
          if (hdr_ok) begin
            state      <= S_LOAD;
            load_len   <= hdr_len;
            expected   <= '0;
            word_count <= '0;
            idle_timer <= '0;
          end else if (wait_timer == BOOT_LAST) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            idle_timer <= '0;
            if (word_addr == expected) begin
              imem_wEn   <= 1'b1;
              imem_waddr <= expected;
              imem_wdata <= word_data;
              expected   <= expected + ADDR_W'(1);
              if (word_count != MAX_LEN) word_count <= word_count + LEN_ONE;
              // The final write is registered here and lands in the first HOLD cycle.
              if (last_word) begin
                state    <= S_HOLD;
                hold_cnt <= '0;
              end
            end else begin
              state      <= S_ERROR;
              boot_error <= 1'b1;
            end
          end else if (idle_timer == WORD_LAST) begin
            state      <= S_ERROR;
            boot_error <= 1'b1;
          end else begin
            idle_timer <= idle_timer + WT_W'(1);
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            boot_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HT_W'(1);
          end
        end
        S_RUN: begin
          if (hdr_ok) begin
            state      <= S_LOAD;
            load_len   <= hdr_len;
            expected   <= '0;
            word_count <= '0;
            idle_timer <= '0;
            cpu_reset  <= 1'b1;
            boot_done  <= 1'b0;
          end
        end
        S_ERROR: begin
          cpu_reset  <= 1'b1;
          boot_error <= 1'b1;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: cycle table for load/reload, scripted sequences for
// timeouts, address errors and reset during a load; writes checked against a queue.
module tb_boot_sequencer;

  localparam int ADDR_W = 12;
  localparam int W      = ADDR_W + 32;
  localparam logic [2:0] S_WAIT = 3'd0, S_LOAD = 3'd1, S_HOLD = 3'd2, S_RUN = 3'd3, S_ERROR = 3'd4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              word_valid = 1'b0;
  logic [31:0]       word_data = '0;
  logic [ADDR_W-1:0] word_addr = '0;
  logic              imem_wEn;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset, boot_done, boot_error;
  logic [ADDR_W:0]   word_count;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  boot_sequencer #(
    .ADDR_W(ADDR_W), .MAGIC(16'hB007), .BOOT_TIMEOUT(50), .WORD_TIMEOUT(20), .RESET_HOLD(4)
  ) dut (
    .clock(clock), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_addr(word_addr), .imem_wEn(imem_wEn), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .boot_done(boot_done),
    .boot_error(boot_error), .word_count(word_count), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected {addr, data}.
  task automatic check_write();
    logic [W-1:0] e;
    if (imem_wEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {imem_waddr, imem_wdata}, '0);
        if ({imem_waddr, imem_wdata} == '0) begin
          n_fail++;
          $display("FAIL unexpected_write: got write to 0 required no write");
        end
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", {imem_waddr, imem_wdata}, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    check_write();
  endtask

  task automatic send(input logic [31:0] data, input logic [ADDR_W-1:0] addr, input bit push);
    word_valid = 1'b1;
    word_data  = data;
    word_addr  = addr;
    if (push) exp_q.push_back({addr, data});
    step();
    word_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},      state_dbg,  S_WAIT);
    chk({tag, "_wen"},        imem_wEn,   0);
    chk({tag, "_waddr"},      imem_waddr, 0);
    chk({tag, "_wdata"},      imem_wdata, 0);
    chk({tag, "_cpu_reset"},  cpu_reset,  1);
    chk({tag, "_boot_done"},  boot_done,  0);
    chk({tag, "_boot_error"}, boot_error, 0);
    chk({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    word_valid = 1'b0;
    step();
    step();
    check_reset_values("reset");
    reset = 1'b0;
  endtask

  // Boot without an image; optional malformed headers must not disturb the timer.
  task automatic timeout_run(input bit bad_hdrs);
    int hold_at = -1;
    int run_at  = -1;
    do_reset();
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (bad_hdrs && cyc == 5)  begin word_valid = 1'b1; word_data = 32'hB007_0000; end
      if (bad_hdrs && cyc == 10) begin word_valid = 1'b1; word_data = 32'hB007_1001; end
      if (bad_hdrs && cyc == 15) begin word_valid = 1'b1; word_data = 32'h1234_0002; end
      step();
      word_valid = 1'b0;
      if (state_dbg == S_HOLD && hold_at < 0) hold_at = cyc;
      if (cpu_reset == 1'b0) begin
        run_at = cyc;
        break;
      end
    end
    chk("timeout_hold_cycle", 64'(hold_at), 50);
    chk("timeout_run_cycle",  64'(run_at),  54);
    chk("timeout_boot_done",  boot_done,    1);
    chk("timeout_word_count", word_count,   0);
  endtask

  typedef struct {
    logic              valid;
    logic [31:0]       data;
    logic [ADDR_W-1:0] addr;
    logic              push;
    logic [2:0]        st;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Load of three words (one carrying MAGIC as data), hold, run, then reload in RUN.
    vecs[0]  = '{1'b1, 32'hB007_0003, 12'd0, 1'b0, S_LOAD, 1'b1, 1'b0, 1'b0, 13'd0};
    vecs[1]  = '{1'b1, 32'h0000_00A0, 12'd0, 1'b1, S_LOAD, 1'b1, 1'b0, 1'b0, 13'd1};
    vecs[2]  = '{1'b1, 32'hB007_0005, 12'd1, 1'b1, S_LOAD, 1'b1, 1'b0, 1'b0, 13'd2};
    vecs[3]  = '{1'b1, 32'h0000_00A2, 12'd2, 1'b1, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd3};
    vecs[4]  = '{1'b0, 32'h0,         12'd0, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd3};
    vecs[5]  = '{1'b1, 32'hB007_0002, 12'd0, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd3};
    vecs[6]  = '{1'b0, 32'h0,         12'd0, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd3};
    vecs[7]  = '{1'b0, 32'h0,         12'd0, 1'b0, S_RUN,  1'b0, 1'b1, 1'b0, 13'd3};
    vecs[8]  = '{1'b1, 32'hB007_0001, 12'd7, 1'b0, S_LOAD, 1'b1, 1'b0, 1'b0, 13'd0};
    vecs[9]  = '{1'b1, 32'hCAFE_0055, 12'd0, 1'b1, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd1};
    vecs[10] = '{1'b0, 32'h0,         12'd0, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd1};
    vecs[11] = '{1'b0, 32'h0,         12'd0, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd1};
    vecs[12] = '{1'b0, 32'h0,         12'd0, 1'b0, S_HOLD, 1'b1, 1'b0, 1'b0, 13'd1};
    vecs[13] = '{1'b0, 32'h0,         12'd0, 1'b0, S_RUN,  1'b0, 1'b1, 1'b0, 13'd1};
    vecs[14] = '{1'b1, 32'h1234_5678, 12'd0, 1'b0, S_RUN,  1'b0, 1'b1, 1'b0, 13'd1};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      word_valid = vecs[i].valid;
      word_data  = vecs[i].data;
      word_addr  = vecs[i].addr;
      if (vecs[i].push) exp_q.push_back({vecs[i].addr, vecs[i].data});
      step();
      word_valid = 1'b0;
      chk($sformatf("vec%0d_state", i),      state_dbg,  vecs[i].st);
      chk($sformatf("vec%0d_cpu_reset", i),  cpu_reset,  vecs[i].cpu_rst);
      chk($sformatf("vec%0d_boot_done", i),  boot_done,  vecs[i].done);
      chk($sformatf("vec%0d_boot_error", i), boot_error, vecs[i].err);
      chk($sformatf("vec%0d_word_count", i), word_count, vecs[i].cnt);
      chk($sformatf("vec%0d_wen", i),        imem_wEn,   vecs[i].push);
    end

    timeout_run(1'b0);
    timeout_run(1'b1);

    // Address mismatch on the second word: one write, then sticky error.
    do_reset();
    send(32'hB007_0002, 12'd0, 1'b0);
    send(32'h0000_0011, 12'd0, 1'b1);
    send(32'h0000_0022, 12'd5, 1'b0);
    chk("addr_err_state", state_dbg,  S_ERROR);
    chk("addr_err_flag",  boot_error, 1);
    chk("addr_err_wen",   imem_wEn,   0);
    for (int i = 0; i < 30; i++) begin
      if (i == 10) send(32'hB007_0001, 12'd0, 1'b0);
      else step();
    end
    chk("addr_err_sticky_state", state_dbg,  S_ERROR);
    chk("addr_err_sticky_flag",  boot_error, 1);
    chk("addr_err_cpu_reset",    cpu_reset,  1);
    chk("addr_err_word_count",   word_count, 1);

    // Idle timeout between words.
    do_reset();
    begin
      int err_at = -1;
      send(32'hB007_0003, 12'd0, 1'b0);
      send(32'h0000_0033, 12'd0, 1'b1);
      for (int cyc = 1; cyc <= 60; cyc++) begin
        step();
        if (boot_error == 1'b1) begin
          err_at = cyc;
          break;
        end
      end
      chk("idle_timeout_cycle", 64'(err_at), 20);
      chk("idle_timeout_state", state_dbg,   S_ERROR);
      chk("idle_timeout_cpu",   cpu_reset,   1);
      chk("idle_timeout_count", word_count,  1);
    end

    // Reset in the middle of a load, then a clean image from address 0.
    do_reset();
    send(32'hB007_0003, 12'd0, 1'b0);
    send(32'h0000_00C0, 12'd0, 1'b1);
    reset = 1'b1;
    step();
    check_reset_values("midload_reset");
    reset = 1'b0;
    send(32'hB007_0003, 12'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(32'hD000_0000 | 32'($urandom_range(0, 255)), 12'(i), 1'b1);
    chk("reload_state", state_dbg,  S_HOLD);
    chk("reload_count", word_count, 3);
    for (int i = 0; i < 4; i++) step();
    chk("reload_run_done", boot_done, 1);
    chk("reload_run_cpu",  cpu_reset, 0);

    chk("pending_writes", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
